// File: rtl/bin16_to_bcd4_seq_if.sv
// Handshake/data bundle between the 0-9999 scaler and the BCD converter.
// The master drives start/bin_in; the slave returns status and the held digits.
interface bin16_to_bcd4_seq_if #(
  parameter int unsigned IN_W = 16
);
  logic            start;
  logic [IN_W-1:0] bin_in;
  logic            busy;
  logic            done;
  logic [15:0]     bcd;
  logic [3:0]      blank;
  logic            ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd, blank, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd, blank, ovf
  );
endinterface

// File: rtl/bin16_to_bcd4_seq.sv
// Saturating 16-bit binary to 4-digit BCD (double dabble, one bit per clock), 17-cycle latency.
// No backpressure: start is honoured only in IDLE, otherwise dropped; outputs hold until the next LOAD.
module bin16_to_bcd4_seq #(
  parameter int unsigned MAX_VAL = 9999,
  parameter int unsigned IN_W    = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  bin16_to_bcd4_seq_if.slave  bus
);

  localparam int unsigned     CNT_W = $clog2(IN_W);
  localparam logic [IN_W-1:0] MAX_W = IN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t           state, state_nxt;
  logic [IN_W-1:0]  bin_sr;
  logic [15:0]      scratch;
  logic [15:0]      adj;
  logic [CNT_W-1:0] count;
  logic             ovf_pending;
  logic             over;
  logic [15:0]      bcd_q;
  logic [3:0]       blank_q;
  logic             ovf_q;
  logic             done_q;

  assign over = (bus.bin_in > MAX_W);

  // Add-3 correction happens before the shift so no nibble ever leaves 0-9.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (count == LAST) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_sr      <= '0;
      scratch     <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      bcd_q       <= '0;
      blank_q     <= 4'b1110;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr      <= over ? MAX_W : bus.bin_in;
            scratch     <= '0;
            count       <= '0;
            ovf_pending <= over;
          end
        end
        SHIFT: begin
          scratch <= {adj[14:0], bin_sr[IN_W-1]};
          bin_sr  <= {bin_sr[IN_W-2:0], 1'b0};
          count   <= count + 1'b1;
        end
        LOAD: begin
          bcd_q      <= scratch;
          ovf_q      <= ovf_pending;
          blank_q[3] <= (scratch[15:12] == 4'd0);
          blank_q[2] <= (scratch[15:8] == 8'd0);
          blank_q[1] <= (scratch[15:4] == 12'd0);
          blank_q[0] <= 1'b0;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.blank = blank_q;
  assign bus.ovf   = ovf_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_bin16_to_bcd4_seq.sv
// Directed and sampled-sweep bench for bin16_to_bcd4_seq; expectations queued at issue, checked on done.
module tb_bin16_to_bcd4_seq;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   done_cnt;
  logic prev_done;
  exp_t q[$];

  bin16_to_bcd4_seq_if #(.IN_W(16)) bif ();

  bin16_to_bcd4_seq #(.MAX_VAL(9999), .IN_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    int s, d3, d2, d1, d0;
    s  = (v > 9999) ? 9999 : v;
    d3 = s / 1000;
    d2 = (s / 100) % 10;
    d1 = (s / 10) % 10;
    d0 = s % 10;
    e.bcd      = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
    e.blank[3] = (d3 == 0);
    e.blank[2] = e.blank[3] && (d2 == 0);
    e.blank[1] = e.blank[2] && (d1 == 0);
    e.blank[0] = 1'b0;
    e.ovf      = (v > 9999);
    e.acc      = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset_n && bif.done) begin
      done_cnt++;
      if (prev_done) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_width: done high in consecutive cycles at cycle %0d", cyc);
      end
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done with no outstanding conversion, bcd=%0h", bif.bcd);
      end else begin
        e = q.pop_front();
        check("bcd",     32'(bif.bcd),   32'(e.bcd));
        check("blank",   32'(bif.blank), 32'(e.blank));
        check("ovf",     32'(bif.ovf),   32'(e.ovf));
        check("latency", 32'(cyc - e.acc), 32'd17);
        check("busy_at_done", 32'(bif.busy), 32'd0);
      end
    end
    prev_done = bif.done;
  end

  // Called at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [15:0] v, input logic [15:0] eb, input logic [3:0] ebl, input logic eo);
    exp_t e;
    e.bcd = eb; e.blank = ebl; e.ovf = eo; e.acc = cyc + 1;
    q.push_back(e);
    bif.start  = 1'b1;
    bif.bin_in = v;
    @(negedge clk);
    bif.start  = 1'b0;
    bif.bin_in = 16'hA5A5;
  endtask

  task automatic issue_model(input int v);
    exp_t e;
    e = model(v);
    issue(16'(v), e.bcd, e.blank, e.ovf);
  endtask

  task automatic stray_start(input logic [15:0] v);
    bif.start  = 1'b1;
    bif.bin_in = v;
    @(negedge clk);
    bif.start  = 1'b0;
  endtask

  initial begin
    int n, d0;
    n_cmp = 0; n_err = 0; cyc = 0; done_cnt = 0; prev_done = 1'b0;
    reset_n    = 1'b0;
    bif.start  = 1'b0;
    bif.bin_in = '0;
    repeat (2) @(negedge clk);
    check("rst_bcd",   32'(bif.bcd),   32'h0);
    check("rst_blank", 32'(bif.blank), 32'hE);
    check("rst_ovf",   32'(bif.ovf),   32'h0);
    check("rst_busy",  32'(bif.busy),  32'h0);
    check("rst_done",  32'(bif.done),  32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(16'd0, 16'h0000, 4'b1110, 1'b0);
    repeat (20) @(negedge clk);

    // 9999: busy must span exactly 17 cycles
    issue(16'd9999, 16'h9999, 4'b0000, 1'b0);
    n = 0;
    while (bif.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'd17);
    repeat (4) @(negedge clk);

    // back-to-back at the earliest accepted edge
    d0 = done_cnt;
    issue(16'd1234, 16'h1234, 4'b0000, 1'b0);
    repeat (17) @(negedge clk);
    issue(16'd40, 16'h0040, 4'b1100, 1'b0);
    repeat (20) @(negedge clk);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    issue(16'd65535, 16'h9999, 4'b0000, 1'b1);
    repeat (17) @(negedge clk);
    issue(16'd7, 16'h0007, 4'b1110, 1'b0);
    repeat (20) @(negedge clk);
    issue(16'd10000, 16'h9999, 4'b0000, 1'b1);
    repeat (20) @(negedge clk);

    // starts during a conversion are dropped
    d0 = done_cnt;
    issue(16'd5000, 16'h5000, 4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    stray_start(16'd1);
    repeat (13) @(negedge clk);
    stray_start(16'd1);
    repeat (25) @(negedge clk);
    check("ignored_done_count", 32'(done_cnt - d0), 32'd1);
    check("ignored_hold_bcd",   32'(bif.bcd),   32'h5000);
    check("ignored_hold_blank", 32'(bif.blank), 32'h0);

    // reset in the middle of a conversion
    issue(16'd1234, 16'h1234, 4'b0000, 1'b0);
    repeat (20) @(negedge clk);
    d0 = done_cnt;
    stray_start(16'd8888);
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_bcd",   32'(bif.bcd),   32'h0);
    check("midrst_blank", 32'(bif.blank), 32'hE);
    check("midrst_busy",  32'(bif.busy),  32'h0);
    check("midrst_done",  32'(bif.done),  32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    issue(16'd8888, 16'h8888, 4'b0000, 1'b0);
    repeat (20) @(negedge clk);

    // sampled sweep against the reference model, back-to-back
    for (int v = 0; v <= 9999; v += 101) begin
      issue_model(v);
      repeat (17) @(negedge clk);
    end
    issue_model(9998);
    repeat (17) @(negedge clk);
    issue_model(9999);
    repeat (17) @(negedge clk);
    issue_model(10000);
    repeat (17) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      issue_model(int'($urandom_range(65535, 10000)));
      repeat (17) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
